// File: rtl/bus_pkg.sv
// Shared definitions for the native parallel bus: state encoding and default widths.
package bus_pkg;

  localparam int unsigned BUS_ADDR_WIDTH = 8;
  localparam int unsigned BUS_DATA_WIDTH = 8;
  localparam logic [BUS_ADDR_WIDTH-1:0] BUS_IDLE_ADDR = {BUS_ADDR_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StWSetup   = 3'd1,
    StWStrobe  = 3'd2,
    StWRecover = 3'd3,
    StRPark    = 3'd4,
    StRAddr    = 3'd5,
    StRStrobe  = 3'd6
  } bus_state_e;

endpackage

// File: rtl/bus_initiator.sv
// Bus initiator: turns valid/ready requests into r_wn/addr/wdata strobe sequences and
// returns read data as a one-cycle response pulse.
module bus_initiator
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = BUS_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = BUS_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] IDLE_ADDR = {ADDR_WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  r_wn,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata
);

  bus_state_e            state_q, state_d;
  logic                  r_wn_q, r_wn_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] tgt_addr_q, tgt_addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  always_comb begin
    state_d     = state_q;
    r_wn_d      = r_wn_q;
    addr_d      = addr_q;
    tgt_addr_d  = tgt_addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          tgt_addr_d = req_addr;
          if (req_write) begin
            state_d = StWSetup;
            addr_d  = req_addr;
            wdata_d = req_wdata;
          end else begin
            // Falling edge lands on the park address, so no endpoint writes.
            state_d = StRPark;
            r_wn_d  = 1'b0;
          end
        end
      end
      StWSetup: begin
        state_d = StWStrobe;
        r_wn_d  = 1'b0;
      end
      StWStrobe: begin
        state_d = StWRecover;
        addr_d  = IDLE_ADDR;
      end
      StWRecover: begin
        state_d     = StIdle;
        r_wn_d      = 1'b1;
        rsp_valid_d = 1'b1;
        rsp_write_d = 1'b1;
        rsp_rdata_d = '0;
      end
      StRPark: begin
        state_d = StRAddr;
        addr_d  = tgt_addr_q;
      end
      StRAddr: begin
        state_d = StRStrobe;
        r_wn_d  = 1'b1;
      end
      StRStrobe: begin
        state_d     = StIdle;
        addr_d      = IDLE_ADDR;
        rsp_valid_d = 1'b1;
        rsp_write_d = 1'b0;
        rsp_rdata_d = rdata;
      end
      default: begin
        state_d = StIdle;
        r_wn_d  = 1'b1;
        addr_d  = IDLE_ADDR;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      r_wn_q      <= 1'b1;
      addr_q      <= IDLE_ADDR;
      tgt_addr_q  <= IDLE_ADDR;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      r_wn_q      <= r_wn_d;
      addr_q      <= addr_d;
      tgt_addr_q  <= tgt_addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign r_wn      = r_wn_q;
  assign addr      = addr_q;
  assign wdata     = wdata_q;

endmodule
